// File: rtl/corr_pkg.sv
// Shared types and default sizes for the correlator lag sweeper.
package corr_pkg;
    localparam int DEF_WIDTH   = 256;
    localparam int DEF_C_WIDTH = 8;

    typedef logic [DEF_C_WIDTH-1:0] lag_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH,
        ABORT
    } state_e;
endpackage

// File: rtl/corr_peak_tracker.sv
// Running maximum of correlator results and the lag that produced it.
module corr_peak_tracker #(
    parameter int WIDTH   = 256,
    parameter int C_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               update_i,
    input  logic [WIDTH-1:0]   result_i,
    input  logic [C_WIDTH-1:0] lag_i,
    output logic [WIDTH-1:0]   peak_value_o,
    output logic [C_WIDTH-1:0] peak_lag_o
);
    logic [WIDTH-1:0]   peak_value_q, peak_value_d;
    logic [C_WIDTH-1:0] peak_lag_q, peak_lag_d;

    always_comb begin
        peak_value_d = peak_value_q;
        peak_lag_d   = peak_lag_q;
        if (clear_i) begin
            peak_value_d = '0;
            peak_lag_d   = '0;
        // lag 0 always loads; strict compare keeps the earliest lag on ties
        end else if (update_i && ((lag_i == '0) || (result_i > peak_value_q))) begin
            peak_value_d = result_i;
            peak_lag_d   = lag_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_value_q <= '0;
            peak_lag_q   <= '0;
        end else begin
            peak_value_q <= peak_value_d;
            peak_lag_q   <= peak_lag_d;
        end
    end

    assign peak_value_o = peak_value_q;
    assign peak_lag_o   = peak_lag_q;
endmodule

// File: rtl/corr_lag_sweeper.sv
// Drives lags 0..MAX_LAG into an external correlator, collects each result,
// tracks the peak, and reports done or a per-lag timeout abort.
module corr_lag_sweeper
    import corr_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int C_WIDTH = DEF_C_WIDTH,
    parameter int MAX_LAG = 2**C_WIDTH - 1,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   signal_1,
    input  logic [WIDTH-1:0]   signal_2,
    output logic [WIDTH-1:0]   corr_sig_1,
    output logic [WIDTH-1:0]   corr_sig_2,
    output logic [C_WIDTH-1:0] count,
    output logic               lag_valid,
    input  logic [WIDTH-1:0]   corr_result,
    input  logic               corr_valid,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [C_WIDTH-1:0] peak_lag,
    output logic [WIDTH-1:0]   peak_value
);
    localparam int                 TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [C_WIDTH-1:0] LAST_LAG = C_WIDTH'(MAX_LAG);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sig_1_q, sig_1_d, sig_2_q, sig_2_d;
    logic [C_WIDTH-1:0] count_q, count_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               peak_clr, peak_upd;

    always_comb begin
        state_d   = state_q;
        sig_1_d   = sig_1_q;
        sig_2_d   = sig_2_q;
        count_d   = count_q;
        tmo_d     = tmo_q;
        peak_clr  = 1'b0;
        peak_upd  = 1'b0;
        lag_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sig_1_d  = signal_1;
                    sig_2_d  = signal_2;
                    count_d  = '0;
                    peak_clr = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                lag_valid = 1'b1;
                busy      = 1'b1;
                tmo_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // a result arriving on the last allowed cycle wins over the timeout
                if (corr_valid) begin
                    peak_upd = 1'b1;
                    if (count_q == LAST_LAG) begin
                        state_d = FINISH;
                    end else begin
                        count_d = count_q + C_WIDTH'(1);
                        state_d = ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ABORT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ABORT: begin
                error   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sig_1_q <= '0;
            sig_2_q <= '0;
            count_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_1_q <= sig_1_d;
            sig_2_q <= sig_2_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
        end
    end

    corr_peak_tracker #(
        .WIDTH   (WIDTH),
        .C_WIDTH (C_WIDTH)
    ) u_peak (
        .clk_i        (clk),
        .rst_i        (reset),
        .clear_i      (peak_clr),
        .update_i     (peak_upd),
        .result_i     (corr_result),
        .lag_i        (count_q),
        .peak_value_o (peak_value),
        .peak_lag_o   (peak_lag)
    );

    assign corr_sig_1 = sig_1_q;
    assign corr_sig_2 = sig_2_q;
    assign count      = count_q;
endmodule
